// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory-port arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, BUSY_I, BUSY_D)
//   req_id_e    : requester identifiers (REQ_I = fetch, REQ_D = load/store)
//   DEF_MEM_LAT : default memory latency in cycles
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    localparam int DEF_MEM_LAT = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the shared
// single-port memory.
//   Fetch port : if_req, if_addr -> if_rdata, if_valid, if_stall
//   Data port  : d_req, d_we, d_addr, d_wdata -> d_rdata, d_valid, d_stall
//   Memory     : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
// Modports: slave = arbiter side, master = requesters + memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          d_stall;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// arb_lat_counter: fixed-latency down-counter for multi-cycle units.
//   clk, reset : clock, asynchronous active-low reset
//   load       : restart the count at MEM_LAT
//   done       : high while the count equals 1 (the next edge ends the access)
// Counts down to 0 and parks there when not reloaded.
module arb_lat_counter #(
    parameter int MEM_LAT = 2,
    parameter int CW      = $clog2(MEM_LAT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             cnt <= '0;
        else if (load)          cnt <= CW'(MEM_LAT);
        else if (cnt != '0)     cnt <= cnt - 1'b1;
    end

    assign done = (cnt == CW'(1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and load/store, sequencing each access over MEM_LAT cycles.
//   clk, reset          : clock, asynchronous active-low reset
//   bus (slave modport) : fetch port, data port and memory port
//   perf_conf, perf_acc : conflict-cycle / completed-access counters
// Optional feature: define ARB_PERF_CNT_EN to build the perf counters;
// otherwise both outputs are tied to zero.
module mem_port_arbiter
    import mips_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic [31:0]         perf_conf,
    output logic [31:0]         perf_acc
);
    arb_state_e    state;
    req_id_e       served;
    logic          cnt_done, cmp, can_grant;
    logic          i_pend, d_pend, grant_i, grant_d;
    logic          cur_we;
    logic          mem_en_q, mem_we_q, if_valid_q, d_valid_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
    logic          if_stall, d_stall;
    logic          unused_lsb;

    arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
        .clk   (clk),
        .reset (reset),
        .load  (grant_i | grant_d),
        .done  (cnt_done)
    );

    assign served    = (state == BUSY_D) ? REQ_D : REQ_I;
    assign cmp       = (state != IDLE) && cnt_done;
    assign can_grant = (state == IDLE) || cmp;

    // A requester whose valid is high now, or is about to go high, still shows
    // the old request on its lines; it must not be granted again.
    assign i_pend = bus.if_req && !if_valid_q && !(cmp && served == REQ_I);
    assign d_pend = bus.d_req  && !d_valid_q  && !(cmp && served == REQ_D);

    // Data wins in IDLE. On a completion edge the served side is never
    // pending, so the other side wins automatically (alternation).
    assign grant_d = can_grant && d_pend;
    assign grant_i = can_grant && i_pend && !d_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cur_we      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_valid_q <= cmp && (served == REQ_I);
            d_valid_q  <= cmp && (served == REQ_D);

            if (cmp && served == REQ_I)            if_rdata_q <= bus.mem_rdata;
            if (cmp && served == REQ_D && !cur_we) d_rdata_q  <= bus.mem_rdata;

            if (grant_d) begin
                state       <= BUSY_D;
                cur_we      <= bus.d_we;
                mem_en_q    <= 1'b1;
                mem_we_q    <= bus.d_we;
                mem_addr_q  <= {2'b00, bus.d_addr[AW-1:2]};
                mem_wdata_q <= bus.d_wdata;
            end else if (grant_i) begin
                state       <= BUSY_I;
                cur_we      <= 1'b0;
                mem_en_q    <= 1'b1;
                mem_addr_q  <= {2'b00, bus.if_addr[AW-1:2]};
            end else if (cmp) begin
                state       <= IDLE;
            end
        end
    end

    assign if_stall = bus.if_req & ~if_valid_q;
    assign d_stall  = bus.d_req  & ~d_valid_q;

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_stall  = if_stall;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_stall   = d_stall;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Word access only: byte-offset bits are dropped.
    assign unused_lsb = &{1'b0, bus.if_addr[1:0], bus.d_addr[1:0]};

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conf_q, acc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conf_q <= '0;
            acc_q  <= '0;
        end else begin
            if (bus.if_req && bus.d_req && (if_stall || d_stall)) conf_q <= conf_q + 32'd1;
            if (cmp)                                                acc_q  <= acc_q + 32'd1;
        end
    end

    assign perf_conf = conf_q;
    assign perf_acc  = acc_q;
`else
    assign perf_conf = '0;
    assign perf_acc  = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (MEM_LAT = 2). Expected memory
// accesses and returned data are queued when stimulus is driven and
// compared when mem_en / if_valid / d_valid appear.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_wd;
    } mem_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] perf_conf, perf_acc;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .perf_conf (perf_conf),
        .perf_acc  (perf_acc)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_err = 0, cyc = 0;
    int          n_ifv = 0, n_dv = 0, en_prev = 0, en_last = 0;
    mem_exp_t    exp_mem[$];
    logic [31:0] exp_if[$], exp_d[$];
    int          lat_q[$];
    logic [31:0] last_d;

    // Memory model: unwritten words read back a fixed pattern; read data is
    // only presented in the cycle before the capture edge.
    bit          wr_vld[256];
    logic [31:0] wr_dat[256];
    int          rd_cnt = 0;
    logic [7:0]  rd_idx = '0;

    function automatic logic [31:0] init_val(input int w);
        return 32'hC0DE_0000 | 32'(w);
    endfunction

    assign bus.mem_rdata = (rd_cnt == 1) ? (wr_vld[rd_idx] ? wr_dat[rd_idx] : init_val(int'(rd_idx)))
                                         : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                wr_vld[bus.mem_addr[7:0]] <= 1'b1;
                wr_dat[bus.mem_addr[7:0]] <= bus.mem_wdata;
            end
            rd_idx <= bus.mem_addr[7:0];
            rd_cnt <= LAT - 1;
        end else if (rd_cnt != 0) begin
            rd_cnt <= rd_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_acc(input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic cw);
        mem_exp_t m;
        m.we = we; m.addr = addr; m.wdata = wd; m.chk_wd = cw;
        exp_mem.push_back(m);
    endtask

    // Monitor: scoreboard pops, sampled away from the active edge.
    always @(negedge clk) begin
        mem_exp_t    m;
        logic [31:0] e;
        if (bus.mem_en) begin
            en_prev = en_last;
            en_last = cyc;
            lat_q.push_back(cyc + LAT);
            chk("mem_en_expected", 32'(exp_mem.size() > 0), 32'd1);
            if (exp_mem.size() > 0) begin
                m = exp_mem.pop_front();
                chk("mem_we", 32'(bus.mem_we), 32'(m.we));
                chk("mem_addr", bus.mem_addr, m.addr);
                if (m.chk_wd) chk("mem_wdata", bus.mem_wdata, m.wdata);
            end
        end
        if (bus.if_valid) begin
            n_ifv++;
            chk("if_valid_expected", 32'(exp_if.size() > 0), 32'd1);
            if (exp_if.size() > 0) begin
                e = exp_if.pop_front();
                chk("if_rdata", bus.if_rdata, e);
            end
            if (lat_q.size() > 0) chk("if_latency", 32'(cyc), 32'(lat_q.pop_front()));
        end
        if (bus.d_valid) begin
            n_dv++;
            chk("d_valid_expected", 32'(exp_d.size() > 0), 32'd1);
            if (exp_d.size() > 0) begin
                e = exp_d.pop_front();
                chk("d_rdata", bus.d_rdata, e);
            end
            if (lat_q.size() > 0) chk("d_latency", 32'(cyc), 32'(lat_q.pop_front()));
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_mem_en"},    32'(bus.mem_en),   32'd0);
        chk({tag, "_mem_we"},    32'(bus.mem_we),   32'd0);
        chk({tag, "_mem_addr"},  bus.mem_addr,      32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata,     32'd0);
        chk({tag, "_if_rdata"},  bus.if_rdata,      32'd0);
        chk({tag, "_d_rdata"},   bus.d_rdata,       32'd0);
        chk({tag, "_if_valid"},  32'(bus.if_valid), 32'd0);
        chk({tag, "_d_valid"},   32'(bus.d_valid),  32'd0);
        chk({tag, "_perf_conf"}, perf_conf,         32'd0);
        chk({tag, "_perf_acc"},  perf_acc,          32'd0);
    endtask

    task automatic wait_v(input bit is_d, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = is_d ? bus.d_valid : bus.if_valid;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic drive_if(input logic [31:0] a);
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = a;
        wait_v(1'b0, "if_valid_seen");
        @(posedge clk); #1;
        bus.if_req = 1'b0;
    endtask

    task automatic drive_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
        wait_v(1'b1, "d_valid_seen");
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.d_we = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (exp_mem.size() == 0 && exp_if.size() == 0 && exp_d.size() == 0) break;
            @(negedge clk);
        end
        chk({tag, "_pending"}, 32'(exp_mem.size() + exp_if.size() + exp_d.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ifv0, dv0, nst;
        bit seen;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // 1: lone fetch; address change after grant must not matter
        exp_acc(1'b0, 32'h4, '0, 1'b0);
        exp_if.push_back(init_val(4));
        ifv0 = n_ifv;
        @(posedge clk); #1 bus.if_req = 1'b1; bus.if_addr = 32'h10;
        @(posedge clk); #1 bus.if_addr = 32'h80;
        wait_v(1'b0, "t1_if_valid");
        @(posedge clk); #1 bus.if_req = 1'b0;
        repeat (3) @(posedge clk);
        chk("t1_if_pulses", 32'(n_ifv - ifv0), 32'd1);

        // 2: simultaneous load + fetch; data first, fetch back-to-back
        exp_acc(1'b0, 32'h40, '0, 1'b0);
        exp_acc(1'b0, 32'h9,  '0, 1'b0);
        exp_d.push_back(init_val(32'h40));
        exp_if.push_back(init_val(9));
        nst = 0;
        fork
            drive_d(1'b0, 32'h100, '0);
            drive_if(32'h24);
            begin
                // count fetch stall cycles from the data grant edge onward
                @(posedge clk); @(posedge clk);
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (bus.if_valid) break;
                    if (bus.if_stall) nst++;
                end
            end
        join
        chk("t2_if_stall_cycles", 32'(nst), 32'd4);
        chk("t2_back_to_back", 32'(en_last - en_prev), 32'(LAT));
        last_d = init_val(32'h40);
        repeat (2) @(posedge clk);

        // 3: store leaves d_rdata alone; misaligned reload returns stored word
        exp_acc(1'b1, 32'h2, 32'hDEAD_BEEF, 1'b1);
        exp_d.push_back(last_d);
        drive_d(1'b1, 32'h8, 32'hDEAD_BEEF);
        exp_acc(1'b0, 32'h2, '0, 1'b0);
        exp_d.push_back(32'hDEAD_BEEF);
        drive_d(1'b0, 32'hB, '0);
        drain("t3");

        // 4: both held 20 cycles from a fresh reset -> strict D,I alternation
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        lat_q.delete();
        for (int k = 0; k < 5; k++) begin
            exp_acc(1'b0, 32'h8, '0, 1'b0);
            exp_acc(1'b0, 32'hC, '0, 1'b0);
            exp_d.push_back(init_val(8));
            exp_if.push_back(init_val(12));
        end
        ifv0 = n_ifv; dv0 = n_dv;
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
        bus.if_req = 1'b1; bus.if_addr = 32'h30;
        repeat (20) @(posedge clk);
        #1 bus.d_req = 1'b0; bus.if_req = 1'b0;
        drain("t4");
        chk("t4_if_completions", 32'(n_ifv - ifv0), 32'd5);
        chk("t4_d_completions",  32'(n_dv - dv0),   32'd5);
`ifdef ARB_PERF_CNT_EN
        chk("t4_perf_acc",  perf_acc,  32'd10);
        chk("t4_perf_conf", perf_conf, 32'd20);
`else
        chk("t4_perf_acc",  perf_acc,  32'd0);
        chk("t4_perf_conf", perf_conf, 32'd0);
`endif
        repeat (2) @(posedge clk);

        // 5: reset in cycle 1 of BUSY_D, then restart from IDLE
        exp_acc(1'b0, 32'h10, '0, 1'b0);
        dv0 = n_dv;
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_en;
        end
        chk("t5_grant", 32'(seen), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        #1 chk_reset("t5_rst");
        repeat (3) @(negedge clk);
        chk("t5_no_d_valid", 32'(n_dv - dv0), 32'd0);
        lat_q.delete();
        exp_acc(1'b0, 32'h10, '0, 1'b0);
        exp_d.push_back(init_val(16));
        @(posedge clk); #1 reset = 1'b1;
        wait_v(1'b1, "t5_restart_valid");
        @(posedge clk); #1 bus.d_req = 1'b0;
        drain("t5");
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
